// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared types and constants for the program loader.
//   loader_state_t : loader FSM states
//   IMEM_WORDS     : instruction-memory depth in words (largest legal program)
//   byte-lane constants used to pack bytes into 32-bit little-endian words
package prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_HOLD,
    ST_RUN,
    ST_ERROR
  } loader_state_t;

  localparam int IMEM_WORDS     = 128;
  localparam int BYTES_PER_WORD = 4;
  localparam int LANE_W         = 2;
  localparam logic [LANE_W-1:0] LAST_LANE = 2'd3;

endpackage

// File: rtl/prog_loader_byte_packer.sv
// byte_packer: packs accepted bytes into 32-bit little-endian words.
//   clk, rst    : clock, synchronous active-high reset
//   clr         : restart packing at lane 0 (new load)
//   byte_en     : a byte is accepted this cycle
//   byte_in     : accepted byte
//   lane        : lane the next accepted byte lands in (byte k -> bits [8k+7:8k])
//   word        : last completed word (registered, held until the next one)
//   word_valid  : one-cycle pulse, the cycle after the 4th byte of a word
module byte_packer
  import prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              byte_en,
  input  logic [7:0]        byte_in,
  output logic [LANE_W-1:0] lane,
  output logic [31:0]       word,
  output logic              word_valid
);

  logic [LANE_W-1:0] lane_reg;
  logic [23:0]       low_reg;     // lanes 0..2 of the word being assembled
  logic [31:0]       word_reg;
  logic              valid_reg;
  logic [BYTES_PER_WORD-2:0] lane_hit;
  logic              last_byte;

  generate
    for (genvar gi = 0; gi < BYTES_PER_WORD - 1; gi++) begin : g_lane
      assign lane_hit[gi] = byte_en && (lane_reg == LANE_W'(gi));
    end
  endgenerate

  assign last_byte = byte_en && (lane_reg == LAST_LANE);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      lane_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      if (byte_en) lane_reg <= lane_reg + 1'b1;
      valid_reg <= last_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      low_reg  <= '0;
      word_reg <= '0;
    end else begin
      for (int i = 0; i < BYTES_PER_WORD - 1; i++) begin
        if (lane_hit[i]) low_reg[8*i +: 8] <= byte_in;
      end
      // The top byte completes the word directly, so the word is ready
      // the cycle after the 4th byte with no extra stage.
      if (last_byte) word_reg <= {byte_in, low_reg};
    end
  end

  assign lane       = lane_reg;
  assign word       = word_reg;
  assign word_valid = valid_reg;

endmodule

// File: rtl/prog_loader.sv
// prog_loader: loads a byte-streamed program into the CPU instruction memory,
// holding the CPU in reset during the load, then releasing it to run from PC 0.
//   clk, rst             : clock, synchronous active-high reset
//   start, num_words     : begin a load of num_words words (legal 1..128)
//   s_data/s_valid/s_ready : byte stream handshake
//   inst_data/inst_addr/inst_wen : IMEM write port
//   cpu_rst, cpu_enb     : CPU reset / PC enable
//   busy, done, err, words_loaded : status
// Optional build macro PROG_LOADER_CHECKSUM_EN: after the program a 4-byte
// XOR checksum word is consumed and verified before the CPU is released.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W   = 7,
  parameter int RST_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        num_words,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [31:0]       inst_data,
  output logic [ADDR_W-1:0] inst_addr,
  output logic              inst_wen,
  output logic              cpu_rst,
  output logic              cpu_enb,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [7:0]        words_loaded
);

  loader_state_t     state_reg, state_next;
  logic              s_ready_reg, s_ready_next;
  logic              wen_reg, wen_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [7:0]        wl_reg, wl_next;       // also the index of the next word
  logic [7:0]        len_reg, len_next;
  logic [7:0]        hold_reg, hold_next;
  logic              cpu_rst_reg, cpu_rst_next;
  logic              cpu_enb_reg, cpu_enb_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              err_reg, err_next;
  logic              packer_clr;

  logic              byte_fire, last_byte;
  logic [LANE_W-1:0] lane;
  logic [31:0]       word;
  logic              word_valid;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [31:0]       xor_reg, xor_next;
`else
  logic              unused_word_valid;
  assign unused_word_valid = word_valid;
`endif

  assign byte_fire = s_valid && s_ready_reg;
  assign last_byte = byte_fire && (lane == LAST_LANE);

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (packer_clr),
    .byte_en    (byte_fire),
    .byte_in    (s_data),
    .lane       (lane),
    .word       (word),
    .word_valid (word_valid)
  );

  always_comb begin
    state_next   = state_reg;
    s_ready_next = s_ready_reg;
    wen_next     = 1'b0;
    addr_next    = addr_reg;
    wl_next      = wl_reg;
    len_next     = len_reg;
    hold_next    = hold_reg;
    cpu_rst_next = cpu_rst_reg;
    cpu_enb_next = cpu_enb_reg;
    done_next    = 1'b0;
    err_next     = err_reg;
    packer_clr   = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
    xor_next     = wen_reg ? (xor_reg ^ word) : xor_reg;
`endif

    case (state_reg)
      ST_IDLE, ST_RUN, ST_ERROR: begin
        if (start) begin
          if (num_words == 8'd0 || num_words > 8'(IMEM_WORDS)) begin
            // CPU outputs are left alone: a running CPU keeps running,
            // a parked one stays parked.
            err_next   = 1'b1;
            state_next = ST_ERROR;
          end else begin
            err_next     = 1'b0;
            len_next     = num_words;
            wl_next      = 8'd0;
            packer_clr   = 1'b1;
            s_ready_next = 1'b1;
            cpu_rst_next = 1'b1;
            cpu_enb_next = 1'b0;
            state_next   = ST_LOAD;
`ifdef PROG_LOADER_CHECKSUM_EN
            xor_next     = '0;
`endif
          end
        end
      end

      ST_LOAD: begin
        if (last_byte) begin
          wen_next  = 1'b1;
          addr_next = wl_reg[ADDR_W-1:0];
          wl_next   = wl_reg + 8'd1;
          if (wl_reg == len_reg - 8'd1) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            // Keep s_ready high: the checksum bytes follow without a bubble.
            state_next   = ST_CHECK;
`else
            // The final write is issued during the first HOLD count, so the
            // counter starts one above RST_HOLD's visible hold window.
            s_ready_next = 1'b0;
            hold_next    = 8'(RST_HOLD);
            state_next   = ST_HOLD;
`endif
          end
        end
      end

`ifdef PROG_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (last_byte) s_ready_next = 1'b0;
        // word_valid coincides with the last program write on CHECK entry;
        // only a word_valid without a write is the checksum word.
        if (word_valid && !wen_reg) begin
          if (word == xor_reg) begin
            hold_next  = 8'(RST_HOLD);
            state_next = ST_HOLD;
          end else begin
            err_next   = 1'b1;
            state_next = ST_ERROR;
          end
        end
      end
`endif

      ST_HOLD: begin
        if (hold_reg == 8'd0) begin
          cpu_rst_next = 1'b0;
          cpu_enb_next = 1'b1;
          done_next    = 1'b1;
          state_next   = ST_RUN;
        end else begin
          hold_next = hold_reg - 8'd1;
        end
      end

      default: state_next = ST_IDLE;
    endcase

    busy_next = (state_next == ST_LOAD) || (state_next == ST_CHECK) ||
                (state_next == ST_HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      s_ready_reg <= 1'b0;
      wen_reg     <= 1'b0;
      addr_reg    <= '0;
      wl_reg      <= 8'd0;
      len_reg     <= 8'd0;
      hold_reg    <= 8'd0;
      cpu_rst_reg <= 1'b1;
      cpu_enb_reg <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      xor_reg     <= '0;
`endif
    end else begin
      state_reg   <= state_next;
      s_ready_reg <= s_ready_next;
      wen_reg     <= wen_next;
      addr_reg    <= addr_next;
      wl_reg      <= wl_next;
      len_reg     <= len_next;
      hold_reg    <= hold_next;
      cpu_rst_reg <= cpu_rst_next;
      cpu_enb_reg <= cpu_enb_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
`ifdef PROG_LOADER_CHECKSUM_EN
      xor_reg     <= xor_next;
`endif
    end
  end

  assign s_ready      = s_ready_reg;
  assign inst_data    = word;
  assign inst_addr    = addr_reg;
  assign inst_wen     = wen_reg;
  assign cpu_rst      = cpu_rst_reg;
  assign cpu_enb      = cpu_enb_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;
  assign err          = err_reg;
  assign words_loaded = wl_reg;

endmodule
